// File: rtl/synapse_spike_scheduler.sv
// Latches spikes per line and dispatches one weighted event per accepted cycle, round-robin, each time step.
// First event is presented the cycle after step_start; syn_ready=0 holds the presented event stable.
module synapse_spike_scheduler #(
    parameter int                 N_IN    = 8,
    parameter int                 IDX_W   = 3,
    parameter logic [N_IN*16-1:0] WEIGHTS = {N_IN{16'h051f}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  spike_in,
    input  logic             step_start,
    input  logic             syn_ready,
    output logic             syn_valid,
    output logic [IDX_W-1:0] syn_idx,
    output logic [15:0]      syn_weight,
    output logic             step_busy,
    output logic             step_done,
    output logic             dropped,
    input  logic             clr_dropped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   pending_q, pending_d;
    logic [N_IN-1:0]   active_q, active_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              dropped_q, dropped_d;

    logic [IDX_W-1:0]  pick_idx;
    logic [N_IN-1:0]   active_after;
    logic              snap;
    logic              xfer;

    // First set bit of act at or after ptr, wrapping from N_IN-1 back to 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_IN-1:0] act,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            j = int'(ptr) + k;
            if (j >= N_IN) begin
                j = j - N_IN;
            end
            if (!found && act[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
        return pick;
    endfunction

    assign pick_idx     = rr_pick(active_q, rr_ptr_q);
    assign active_after = active_q & ~(N_IN'(1) << pick_idx);
    assign syn_valid    = (state_q == S_DISPATCH) && (active_q != '0);
    assign syn_idx      = syn_valid ? pick_idx : '0;
    assign syn_weight   = syn_valid ? WEIGHTS[16*pick_idx +: 16] : 16'h0000;
    assign step_busy    = (state_q != S_IDLE);
    assign step_done    = (state_q == S_DONE);
    assign dropped      = dropped_q;
    assign snap         = (state_q == S_IDLE) && step_start;
    assign xfer         = syn_valid && syn_ready;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        rr_ptr_d  = rr_ptr_q;
        pending_d = pending_q | spike_in;
        dropped_d = dropped_q;

        // Spikes arriving with the snapshot belong to this step, so they are never drops.
        if (snap) begin
            pending_d = '0;
        end
        if (!snap && ((pending_q & spike_in) != '0)) begin
            dropped_d = 1'b1;
        end else if (clr_dropped) begin
            dropped_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    active_d = pending_q | spike_in;
                    state_d  = ((pending_q | spike_in) != '0) ? S_DISPATCH : S_DONE;
                end
            end
            S_DISPATCH: begin
                if (active_q == '0) begin
                    state_d = S_DONE;
                end else if (xfer) begin
                    active_d = active_after;
                    rr_ptr_d = (pick_idx == IDX_W'(N_IN - 1)) ? '0 : pick_idx + 1'b1;
                    if (active_after == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            active_q  <= '0;
            rr_ptr_q  <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            rr_ptr_q  <= rr_ptr_d;
            dropped_q <= dropped_d;
        end
    end

endmodule

// File: tb/tb_synapse_spike_scheduler.sv
// Randomized bench for synapse_spike_scheduler with a set-based reference model of pending/round-robin order.
module tb_synapse_spike_scheduler;

    localparam logic [15:0] WT [8] = '{16'h051f, 16'h0630, 16'h0741, 16'h0852,
                                       16'h0963, 16'h0a74, 16'h0b85, 16'h0c96};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  spike_in;
    logic        step_start;
    logic        syn_ready;
    logic        clr_dropped;
    logic        syn_valid;
    logic [2:0]  syn_idx;
    logic [15:0] syn_weight;
    logic        step_busy;
    logic        step_done;
    logic        dropped;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_pend;
    int         m_rr;
    logic       m_drop;
    int         exp_idx[$];

    // Observations from the last run_step
    int          obs_idx[$];
    logic [15:0] obs_w[$];
    int          done_at;

    synapse_spike_scheduler #(
        .N_IN   (8),
        .IDX_W  (3),
        .WEIGHTS({16'h0c96, 16'h0b85, 16'h0a74, 16'h0963,
                  16'h0852, 16'h0741, 16'h0630, 16'h051f})
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .step_start (step_start),
        .syn_ready  (syn_ready),
        .syn_valid  (syn_valid),
        .syn_idx    (syn_idx),
        .syn_weight (syn_weight),
        .step_busy  (step_busy),
        .step_done  (step_done),
        .dropped    (dropped),
        .clr_dropped(clr_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_pend = 8'h00;
        m_rr   = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_spike(input logic [7:0] sp);
        if ((m_pend & sp) != 8'h00) m_drop = 1'b1;
        m_pend = m_pend | sp;
    endtask

    // Serve the snapshot set: repeatedly take the nearest member at or after the pointer.
    task automatic model_step(input logic [7:0] sp, input logic [7:0] late);
        bit set [8];
        int left;
        left = 0;
        for (int i = 0; i < 8; i++) begin
            set[i] = m_pend[i] | sp[i];
            if (set[i]) left++;
        end
        m_pend = 8'h00;
        exp_idx.delete();
        while (left > 0) begin
            for (int k = 0; k < 8; k++) begin
                if (set[(m_rr + k) % 8]) begin
                    exp_idx.push_back((m_rr + k) % 8);
                    set[(m_rr + k) % 8] = 0;
                    m_rr = ((m_rr + k) % 8 + 1) % 8;
                    left--;
                    break;
                end
            end
        end
        m_pend = late;
    endtask

    task automatic drive_spikes(input logic [7:0] sp, input logic clr);
        spike_in    = sp;
        clr_dropped = clr;
        tick;
        spike_in    = 8'h00;
        clr_dropped = 1'b0;
    endtask

    // Runs one step and records accepted events plus the cycle of step_done.
    task automatic run_step(input logic [7:0] sp, input bit rnd, input logic [7:0] late);
        obs_idx.delete();
        obs_w.delete();
        done_at    = -1;
        spike_in   = sp;
        step_start = 1'b1;
        tick;
        step_start = 1'b0;
        spike_in   = late;
        for (int c = 1; c <= 300; c++) begin
            if (step_done) begin
                done_at = c;
                break;
            end
            syn_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (syn_valid && syn_ready) begin
                obs_idx.push_back(int'(syn_idx));
                obs_w.push_back(syn_weight);
            end
            tick;
            spike_in = 8'h00;
        end
        syn_ready = 1'b0;
        tick;
        spike_in = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1; spike_in = 8'h00; step_start = 1'b0; syn_ready = 1'b0; clr_dropped = 1'b0;
        model_reset();
        repeat (2) tick;
        n_tests++;
        if ({syn_valid, syn_idx, syn_weight, step_busy, step_done, dropped} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b idx=%0d w=%h busy=%0b done=%0b drop=%0b, want all 0",
                     syn_valid, syn_idx, syn_weight, step_busy, step_done, dropped);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_tests++;
            if (step_done !== 1'b0 || step_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_done: cycle %0d done=%0b busy=%0b, want 0 0", c, step_done, step_busy);
            end
        end
    endtask

    task automatic test_basic;
        // Two steps: {0,2} from pointer 0, then {1,7} from pointer 3 wraps to 7 first.
        logic [7:0] pats [2] = '{8'b0000_0101, 8'b1000_0010};
        int         want_first [2] = '{0, 7};
        for (int s = 0; s < 2; s++) begin
            model_spike(pats[s]);
            drive_spikes(pats[s], 1'b0);
            model_step(8'h00, 8'h00);
            run_step(8'h00, 1'b0, 8'h00);
            n_tests++;
            if (obs_idx.size() !== exp_idx.size() || obs_idx.size() == 0 || obs_idx[0] !== want_first[s]) begin
                n_fail++;
                $display("FAIL basic_order s%0d: got %0d events first=%0d, want %0d events first=%0d",
                         s, obs_idx.size(), (obs_idx.size() > 0) ? obs_idx[0] : -1, exp_idx.size(), want_first[s]);
            end
            for (int i = 0; i < obs_idx.size() && i < exp_idx.size(); i++) begin
                n_tests++;
                if (obs_idx[i] !== exp_idx[i] || obs_w[i] !== WT[exp_idx[i]]) begin
                    n_fail++;
                    $display("FAIL basic_event s%0d.%0d: got idx=%0d w=%h, want idx=%0d w=%h",
                             s, i, obs_idx[i], obs_w[i], exp_idx[i], WT[exp_idx[i]]);
                end
            end
            n_tests++;
            if (done_at !== exp_idx.size() + 1) begin
                n_fail++;
                $display("FAIL basic_done s%0d: step_done at +%0d, want +%0d", s, done_at, exp_idx.size() + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        model_spike(8'h38);
        drive_spikes(8'h38, 1'b0);
        model_step(8'h00, 8'h00);
        syn_ready  = 1'b0;
        step_start = 1'b1;
        tick;
        step_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (syn_valid !== 1'b1 || int'(syn_idx) !== exp_idx[0] || syn_weight !== WT[exp_idx[0]] || step_done !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall c%0d: got valid=%0b idx=%0d w=%h done=%0b, want 1 %0d %h 0",
                         c, syn_valid, syn_idx, syn_weight, step_done, exp_idx[0], WT[exp_idx[0]]);
            end
            step_start = (c == 1);  // must be ignored outside IDLE
            tick;
            step_start = 1'b0;
        end
        syn_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (syn_valid !== 1'b1 || int'(syn_idx) !== exp_idx[c]) begin
                n_fail++;
                $display("FAIL bp_drain c%0d: got valid=%0b idx=%0d, want 1 %0d", c, syn_valid, syn_idx, exp_idx[c]);
            end
            tick;
        end
        syn_ready = 1'b0;
        n_tests++;
        if (step_done !== 1'b1 || syn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: got done=%0b valid=%0b, want 1 0", step_done, syn_valid);
        end
        tick;
        n_tests++;
        if (step_busy !== 1'b0 || step_done !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got busy=%0b done=%0b, want 0 0", step_busy, step_done);
        end
    endtask

    task automatic test_drop;
        model_spike(8'h10); drive_spikes(8'h10, 1'b0);
        model_spike(8'h10); drive_spikes(8'h10, 1'b0);
        tick;
        n_tests++;
        if (dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_set: got dropped=%0b, want 1", dropped);
        end
        drive_spikes(8'h00, 1'b1);
        n_tests++;
        if (dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear: got dropped=%0b, want 0", dropped);
        end
        // Another hit on the still-pending line together with a clear: the drop wins.
        drive_spikes(8'h10, 1'b1);
        n_tests++;
        if (dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_wins: got dropped=%0b, want 1", dropped);
        end
        drive_spikes(8'h00, 1'b1);
        m_drop = 1'b0;
        // A spike on the pending line in the snapshot cycle is part of the step, not a drop.
        model_step(8'h10, 8'h00);
        run_step(8'h10, 1'b0, 8'h00);
        n_tests++;
        if (obs_idx.size() !== 1 || obs_idx[0] !== 4 || dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_single: got %0d events first=%0d dropped=%0b, want 1 event idx 4 dropped 0",
                     obs_idx.size(), (obs_idx.size() > 0) ? obs_idx[0] : -1, dropped);
        end
    endtask

    task automatic test_empty_and_late;
        model_step(8'h00, 8'h00);
        run_step(8'h00, 1'b0, 8'h00);
        n_tests++;
        if (obs_idx.size() !== 0 || done_at !== 1) begin
            n_fail++;
            $display("FAIL empty_step: got %0d events done at +%0d, want 0 events done at +1", obs_idx.size(), done_at);
        end
        model_spike(8'h03);
        drive_spikes(8'h03, 1'b0);
        model_step(8'h00, 8'h20);
        run_step(8'h00, 1'b0, 8'h20);
        n_tests++;
        if (obs_idx.size() !== 2 || obs_idx[0] !== exp_idx[0] || obs_idx[1] !== exp_idx[1]) begin
            n_fail++;
            $display("FAIL late_first: got %0d events, want %0d (line 5 excluded)", obs_idx.size(), exp_idx.size());
        end
        model_step(8'h00, 8'h00);
        run_step(8'h00, 1'b0, 8'h00);
        n_tests++;
        if (obs_idx.size() !== 1 || obs_idx[0] !== 5 || obs_w[0] !== WT[5] || dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL late_next: got %0d events first=%0d dropped=%0b, want 1 event idx 5 dropped 0",
                     obs_idx.size(), (obs_idx.size() > 0) ? obs_idx[0] : -1, dropped);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 25; it++) begin
            int         npre;
            logic [7:0] sp;
            logic [7:0] late;
            npre = $urandom_range(1, 3);
            for (int p = 0; p < npre; p++) begin
                sp = 8'($urandom & $urandom);
                model_spike(sp);
                drive_spikes(sp, 1'b0);
            end
            sp   = 8'($urandom & $urandom);
            late = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            model_step(sp, late);
            run_step(sp, 1'b1, late);
            n_tests++;
            if (obs_idx.size() !== exp_idx.size() || done_at < exp_idx.size() + 1) begin
                n_fail++;
                $display("FAIL rand_count it%0d: got %0d events done at +%0d, want %0d events done >= +%0d",
                         it, obs_idx.size(), done_at, exp_idx.size(), exp_idx.size() + 1);
            end
            for (int i = 0; i < obs_idx.size() && i < exp_idx.size(); i++) begin
                n_tests++;
                if (obs_idx[i] !== exp_idx[i] || obs_w[i] !== WT[exp_idx[i]]) begin
                    n_fail++;
                    $display("FAIL rand_event it%0d.%0d: got idx=%0d w=%h, want idx=%0d w=%h",
                             it, i, obs_idx[i], obs_w[i], exp_idx[i], WT[exp_idx[i]]);
                end
            end
            n_tests++;
            if (dropped !== m_drop) begin
                n_fail++;
                $display("FAIL rand_dropped it%0d: got %0b, want %0b", it, dropped, m_drop);
            end
            if (m_drop) begin
                drive_spikes(8'h00, 1'b1);
                m_drop = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid;
        model_spike(8'h01); drive_spikes(8'h01, 1'b0);
        model_spike(8'h41); drive_spikes(8'h41, 1'b0);
        syn_ready  = 1'b0;
        step_start = 1'b1;
        tick;
        step_start = 1'b0;
        spike_in   = 8'h04;
        tick;
        spike_in   = 8'h00;
        n_tests++;
        if (syn_valid !== 1'b1 || dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got valid=%0b dropped=%0b, want 1 1", syn_valid, dropped);
        end
        rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if ({syn_valid, syn_idx, syn_weight, step_busy, step_done, dropped} !== 22'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got valid=%0b idx=%0d w=%h busy=%0b done=%0b drop=%0b, want all 0",
                     syn_valid, syn_idx, syn_weight, step_busy, step_done, dropped);
        end
        tick;
        rst = 1'b0;
        tick;
        run_step(8'h00, 1'b0, 8'h00);
        n_tests++;
        if (obs_idx.size() !== 0 || done_at !== 1) begin
            n_fail++;
            $display("FAIL rstmid_empty: got %0d events done at +%0d, want 0 events done at +1", obs_idx.size(), done_at);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_empty_and_late();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
